// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/bubble/setcc control for a five-stage Y86-64 style pipeline. It covers
// load-use, mispredict and return hazards. A multi-cycle execute op holds the
// E stage through a busy counter. A sticky HALTED state freezes the pipeline
// once a bad status retires.
// Optional build macro PIPE_HAZARD_PERF_EN adds saturating stall/bubble
// cycle counters (stall_cycles, bubble_cycles).
module pipeline_hazard_ctrl #(
  parameter int               REG_W     = 4,
  parameter logic [REG_W-1:0] RNONE     = 4'hF,
  parameter logic [3:0]       LOAD_IC_A = 4'h5,
  parameter logic [3:0]       LOAD_IC_B = 4'hB,
  parameter logic [3:0]       JXX_IC    = 4'h7,
  parameter logic [3:0]       RET_IC    = 4'h9,
  parameter logic [3:0]       HALT_IC   = 4'h0,
  parameter logic [3:0]       STAT_AOK  = 4'b1000,
`ifdef PIPE_HAZARD_PERF_EN
  parameter int               CNT_W     = 16,
`endif
  parameter int               EX_CYCLES = 3,
  localparam int              BUSY_W    = ($clog2(EX_CYCLES) < 2) ? 2 : $clog2(EX_CYCLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        D_icode,
  input  logic [REG_W-1:0]  d_srcA,
  input  logic [REG_W-1:0]  d_srcB,
  input  logic [3:0]        E_icode,
  input  logic [REG_W-1:0]  E_destM,
  input  logic              E_multi,
  input  logic              e_Cnd,
  input  logic [3:0]        M_icode,
  input  logic [3:0]        m_stat,
  input  logic [3:0]        W_stat,
  output logic              setcc,
  output logic              F_stall,
  output logic              D_stall,
  output logic              E_stall,
  output logic              W_stall,
  output logic              D_bubble,
  output logic              E_bubble,
  output logic              M_bubble,
  output logic              halted,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  bubble_cycles,
`endif
  output logic [BUSY_W-1:0] busy_cnt
);

  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(EX_CYCLES - 1);
  localparam logic [BUSY_W-1:0] BUSY_ONE  = BUSY_W'(1);

  state_t state;
  logic   lu;
  logic   mp;
  logic   rt;
  logic   busy;
  logic   m_fault;
  logic   w_fault;

  assign lu = ((E_icode == LOAD_IC_A) || (E_icode == LOAD_IC_B)) &&
              (E_destM != RNONE) &&
              ((E_destM == d_srcA) || (E_destM == d_srcB));
  assign mp = (E_icode == JXX_IC) && !e_Cnd;
  assign rt = (D_icode == RET_IC) || (E_icode == RET_IC) || (M_icode == RET_IC);
  assign busy = (busy_cnt != '0) || (E_multi && (busy_cnt == '0));
  assign m_fault = (m_stat != STAT_AOK);
  assign w_fault = (W_stat != STAT_AOK);

  // Resolve hazards by priority into stage-register stall/bubble/setcc controls
  always_comb begin
    setcc    = 1'b1;
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    E_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    if (state == HALTED) begin
      setcc   = 1'b0;
      F_stall = 1'b1;
      D_stall = 1'b1;
      E_stall = 1'b1;
      W_stall = 1'b1;
    end else begin
      if (busy) begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_stall  = 1'b1;
        M_bubble = 1'b1;
      end else if (mp) begin
        D_bubble = 1'b1;
        E_bubble = 1'b1;
      end else if (lu) begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_bubble = 1'b1;
      end else if (rt) begin
        F_stall  = 1'b1;
        D_bubble = 1'b1;
      end
      if (m_fault) begin
        M_bubble = 1'b1;
      end
      if (w_fault) begin
        W_stall = 1'b1;
      end
      setcc = !((E_icode == HALT_IC) || m_fault || w_fault);
    end
  end

  // Sticky halt FSM: a bad status reaching writeback freezes the pipe until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (w_fault) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          state  <= HALTED;
          halted <= 1'b1;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // Count down the remaining execute cycles of a multi-cycle op; frozen when halted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
    end else if (state == RUN) begin
      if (busy_cnt != '0) begin
        busy_cnt <= busy_cnt - BUSY_ONE;
      end else if (E_multi) begin
        busy_cnt <= BUSY_LOAD;
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Saturating counts of stall and bubble cycles while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
    end else if (state == RUN) begin
      if (F_stall && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + CNT_ONE;
      end
      if ((D_bubble || E_bubble) && (bubble_cycles != CNT_MAX)) begin
        bubble_cycles <= bubble_cycles + CNT_ONE;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Directed and randomized checks of pipeline_hazard_ctrl. A behavioural model
// tracks the halt flag and the remaining busy cycles as integers. It derives
// the expected controls from the hazard priority rules each cycle.
module tb_pipeline_hazard_ctrl;

  localparam logic [3:0] AOK   = 4'b1000;
  localparam logic [3:0] RNONE = 4'hF;
  localparam int         EXC   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_destM, M_icode, m_stat, W_stat;
  logic       E_multi, e_Cnd;
  logic       setcc, F_stall, D_stall, E_stall, W_stall;
  logic       D_bubble, E_bubble, M_bubble, halted;
  logic [1:0] busy_cnt;
`ifdef PIPE_HAZARD_PERF_EN
  logic [15:0] stall_cycles, bubble_cycles;
  int          mdl_stalls;
  int          mdl_bubbles;
`endif

  int    checks = 0;
  int    failures = 0;
  string phase;
  bit    mdl_halted;
  int    mdl_rem;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_destM(E_destM), .E_multi(E_multi), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .setcc(setcc), .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall),
    .W_stall(W_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .halted(halted),
`ifdef PIPE_HAZARD_PERF_EN
    .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles),
`endif
    .busy_cnt(busy_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Observed controls packed as {setcc,F,D,E,W stall,D,E,M bubble,halted}
  function automatic logic [8:0] ctrlVec();
    return {setcc, F_stall, D_stall, E_stall, W_stall, D_bubble, E_bubble, M_bubble, halted};
  endfunction

  function automatic logic [8:0] expectCtrl();
    bit load_use, mispred, ret_seen, busy_now, m_bad, w_bad;
    bit fs, ds, es, db, eb, mb;
    if (mdl_halted) return 9'b0_1111_000_1;
    load_use = (E_icode == 4'h5 || E_icode == 4'hB) && E_destM != RNONE &&
               (E_destM == d_srcA || E_destM == d_srcB);
    mispred  = (E_icode == 4'h7) && !e_Cnd;
    ret_seen = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
    busy_now = (mdl_rem > 0) || E_multi;
    m_bad    = (m_stat != AOK);
    w_bad    = (W_stat != AOK);
    {fs, ds, es, db, eb, mb} = '0;
    if (busy_now)      begin fs = 1; ds = 1; es = 1; mb = 1; end
    else if (mispred)  begin db = 1; eb = 1; end
    else if (load_use) begin fs = 1; ds = 1; eb = 1; end
    else if (ret_seen) begin fs = 1; db = 1; end
    if (m_bad) mb = 1;
    return {!(E_icode == 4'h0 || m_bad || w_bad), fs, ds, es, w_bad, db, eb, mb, 1'b0};
  endfunction

  task automatic setNeutral();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
    d_srcA = RNONE; d_srcB = RNONE; E_destM = RNONE;
    E_multi = 1'b0; e_Cnd = 1'b1; m_stat = AOK; W_stat = AOK;
  endtask

  task automatic resetModel();
    mdl_halted = 1'b0;
    mdl_rem = 0;
`ifdef PIPE_HAZARD_PERF_EN
    mdl_stalls = 0;
    mdl_bubbles = 0;
`endif
  endtask

  // Called at posedge+1 with inputs already driven: check at negedge, advance model
  task automatic applyStimulus();
    logic [8:0] exp_ctrl;
    #4;
    exp_ctrl = expectCtrl();
    checkOutput({phase, ".ctrl"}, 32'(ctrlVec()), 32'(exp_ctrl));
    checkOutput({phase, ".busy_cnt"}, 32'(busy_cnt), mdl_rem);
`ifdef PIPE_HAZARD_PERF_EN
    checkOutput({phase, ".stall_cycles"}, 32'(stall_cycles), mdl_stalls);
    checkOutput({phase, ".bubble_cycles"}, 32'(bubble_cycles), mdl_bubbles);
`endif
    if (!mdl_halted) begin
`ifdef PIPE_HAZARD_PERF_EN
      if (exp_ctrl[7] && mdl_stalls < 65535) mdl_stalls++;
      if ((exp_ctrl[3] || exp_ctrl[2]) && mdl_bubbles < 65535) mdl_bubbles++;
`endif
      if (mdl_rem > 0) mdl_rem--;
      else if (E_multi) mdl_rem = EXC - 1;
      if (W_stat != AOK) mdl_halted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1: assert reset between edges and check it takes effect at once
  task automatic asyncReset();
    setNeutral();
    #2;
    rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput({phase, ".rst_busy_cnt"}, 32'(busy_cnt), 32'd0);
    checkOutput({phase, ".rst_ctrl"}, 32'(ctrlVec()), 32'(9'b1_0000_000_0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] pickIcode();
    case ($urandom_range(0, 7))
      0: return 4'h0;
      1: return 4'h1;
      2: return 4'h2;
      3: return 4'h5;
      4: return 4'hB;
      5: return 4'h7;
      6: return 4'h9;
      default: return 4'h6;
    endcase
  endfunction

  function automatic logic [3:0] pickReg();
    if ($urandom_range(0, 4) == 0) return RNONE;
    return 4'($urandom_range(0, 3));
  endfunction

  initial begin
    rst_n = 1'b0;
    setNeutral();
    resetModel();
    phase = "reset";
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.busy_cnt", 32'(busy_cnt), 32'd0);
    checkOutput("reset.ctrl", 32'(ctrlVec()), 32'(9'b1_0000_000_0));
    rst_n = 1'b1;

    phase = "idle";            applyStimulus();
    phase = "load_use";        E_icode = 4'h5; E_destM = 4'h3; d_srcA = 4'h3; applyStimulus();
    phase = "load_use_rnone";  E_destM = RNONE; d_srcA = RNONE; applyStimulus();
    phase = "load_use_srcB";   E_icode = 4'hB; E_destM = 4'h2; d_srcB = 4'h2; applyStimulus();

    setNeutral();
    phase = "mispredict";      E_icode = 4'h7; e_Cnd = 1'b0; applyStimulus();
    phase = "mispredict_ret";  D_icode = 4'h9; applyStimulus();
    phase = "jxx_taken";       e_Cnd = 1'b1; D_icode = 4'h1; applyStimulus();

    setNeutral();
    phase = "multi";
    E_multi = 1'b1; E_icode = 4'h5; E_destM = 4'h2; d_srcB = 4'h2;
    applyStimulus();
    E_multi = 1'b0;
    repeat (3) applyStimulus();

    setNeutral();
    phase = "ret";
    D_icode = 4'h9; applyStimulus();
    D_icode = 4'h1; E_icode = 4'h9; applyStimulus();
    E_icode = 4'h1; M_icode = 4'h9; applyStimulus();
    M_icode = 4'h1; applyStimulus();

    phase = "lu_over_ret";
    E_icode = 4'h5; E_destM = 4'h3; d_srcA = 4'h3; D_icode = 4'h9; applyStimulus();

    setNeutral();
    phase = "halt_icode";      E_icode = 4'h0; applyStimulus();

    setNeutral();
    phase = "exception";
    m_stat = 4'b0010; applyStimulus();
    m_stat = AOK; W_stat = 4'b0010; applyStimulus();
    W_stat = AOK; E_icode = 4'h7; e_Cnd = 1'b0; E_multi = 1'b1;
    repeat (3) applyStimulus();
    asyncReset();
    phase = "after_reset";     setNeutral(); applyStimulus();

    phase = "halt_while_busy";
    E_multi = 1'b1; applyStimulus();
    E_multi = 1'b0; W_stat = 4'b0100; applyStimulus();
    W_stat = AOK; repeat (2) applyStimulus();
    asyncReset();

    phase = "async_reset";
    setNeutral();
    E_multi = 1'b1; applyStimulus();
    E_multi = 1'b0;
    checkOutput("async_reset.busy_pre", 32'(busy_cnt), 32'd2);
    asyncReset();
    phase = "async_reset_after"; applyStimulus();

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      if (mdl_halted && $urandom_range(0, 3) == 0) begin
        asyncReset();
      end else begin
        D_icode = pickIcode();
        E_icode = pickIcode();
        M_icode = pickIcode();
        d_srcA  = pickReg();
        d_srcB  = pickReg();
        E_destM = pickReg();
        E_multi = ($urandom_range(0, 7) == 0);
        e_Cnd   = 1'($urandom_range(0, 1));
        m_stat  = ($urandom_range(0, 19) == 0) ? 4'b0010 : AOK;
        W_stat  = ($urandom_range(0, 39) == 0) ? 4'b0100 : AOK;
        applyStimulus();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
